// File: rtl/cpu_pkg.sv
// Shared definitions for the 4-bit CPU: default bus widths, opcode encodings
// and the memory responder state enum.
package cpu_pkg;

    localparam int CPU_ADDR_W = 4;
    localparam int CPU_DATA_W = 8;

    // Opcode lives in word[7:4], operand in word[3:0].
    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_LOAD  = 4'h1;
    localparam logic [3:0] OP_ADD   = 4'h2;
    localparam logic [3:0] OP_SUB   = 4'h3;
    localparam logic [3:0] OP_AND   = 4'h4;
    localparam logic [3:0] OP_OR    = 4'h5;
    localparam logic [3:0] OP_STORE = 4'h6;
    localparam logic [3:0] OP_JMP   = 4'h7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2,
        ST_LOAD = 2'd3
    } resp_state_t;

endpackage

// File: rtl/cpu_mem_array.sv
// Program/data store: one synchronous write port, one combinational read port.
// Contents are not reset so a loaded program survives a core reset.
module cpu_mem_array #(
    parameter int ADDR_W = 4,
    parameter int WORD_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WORD_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WORD_W-1:0] rdata
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [WORD_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/cpu_mem_responder.sv
// Memory-side responder: wait-stated reads, store writes and a byte-serial program load port.
// Define CPU_MEM_PARITY_EN to store an even-parity bit per word and report it on rd_err.
module cpu_mem_responder
    import cpu_pkg::*;
#(
    parameter int ADDR_W  = CPU_ADDR_W,
    parameter int DATA_W  = CPU_DATA_W,
    parameter int LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_ready,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_err,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ack,
    input  logic              ld_en,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_done,
    output logic              busy
);

`ifdef CPU_MEM_PARITY_EN
    localparam int WORD_W = DATA_W + 1;
`else
    localparam int WORD_W = DATA_W;
`endif

    resp_state_t       state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              enter_resp;

    logic [DATA_W-1:0] rd_data_q;
    logic              rd_err_q;
    logic              wr_ack_q;
    logic              ld_done_q;

    logic              load_we, store_we, mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic [WORD_W-1:0] mem_wword;
    logic [ADDR_W-1:0] mem_raddr;
    logic [WORD_W-1:0] mem_rword;
    logic              fwd_hit;
    logic              stored_err;

    // Load owns the write port in LOAD; stores own it everywhere else.
    assign load_we   = (state_q == ST_LOAD) && ld_valid;
    assign store_we  = (state_q != ST_LOAD) && wr_req;
    assign mem_we    = load_we || store_we;
    assign mem_waddr = load_we ? ptr_q : wr_addr;
    assign mem_wdata = load_we ? ld_data : wr_data;

    // A zero-latency read captures on the accept edge, before addr_q is loaded.
    assign mem_raddr = (state_q == ST_IDLE) ? rd_addr : addr_q;
    assign fwd_hit   = store_we && (wr_addr == mem_raddr);

`ifdef CPU_MEM_PARITY_EN
    assign mem_wword  = {^mem_wdata, mem_wdata};
    assign stored_err = mem_rword[DATA_W] ^ (^mem_rword[DATA_W-1:0]);
`else
    assign mem_wword  = mem_wdata;
    assign stored_err = 1'b0;
`endif

    cpu_mem_array #(
        .ADDR_W (ADDR_W),
        .WORD_W (WORD_W)
    ) u_array (
        .clk   (clk),
        .we    (mem_we),
        .waddr (mem_waddr),
        .wdata (mem_wword),
        .raddr (mem_raddr),
        .rdata (mem_rword)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        ptr_d      = ptr_q;
        enter_resp = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (ld_en) begin
                    state_d = ST_LOAD;
                end else if (rd_req) begin
                    addr_d = rd_addr;
                    cnt_d  = 3'(LATENCY);
                    if (LATENCY == 0) begin
                        state_d    = ST_RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 3'd1;
                if (cnt_q == 3'd1) begin
                    state_d    = ST_RESP;
                    enter_resp = 1'b1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            ST_LOAD: begin
                if (ld_valid) begin
                    ptr_d = ptr_q + 1'b1;
                end
                if (!ld_en) begin
                    ptr_d   = '0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            ptr_q     <= '0;
            rd_data_q <= '0;
            rd_err_q  <= 1'b0;
            wr_ack_q  <= 1'b0;
            ld_done_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            ptr_q     <= ptr_d;
            wr_ack_q  <= store_we;
            ld_done_q <= (state_q == ST_LOAD) && !ld_en;
            rd_err_q  <= enter_resp && !fwd_hit && stored_err;
            if (enter_resp) begin
                rd_data_q <= fwd_hit ? wr_data : mem_rword[DATA_W-1:0];
            end
        end
    end

    assign rd_ready = (state_q == ST_IDLE) && !reset;
    assign rd_valid = (state_q == ST_RESP);
    assign rd_data  = rd_data_q;
    assign rd_err   = rd_err_q;
    assign wr_ack   = wr_ack_q;
    assign ld_done  = ld_done_q;
    assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Directed bench for cpu_mem_responder with LATENCY=3: program load, table of
// write/read vectors, and hand-written wait-state, forwarding, reset and load corner cases.
module tb_cpu_mem_responder;
    import cpu_pkg::*;

    localparam int AW  = 4;
    localparam int DW  = 8;
    localparam int LAT = 3;

    logic          clk;
    logic          reset;
    logic          rd_req;
    logic [AW-1:0] rd_addr;
    logic          rd_ready;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic          rd_err;
    logic          wr_req;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          wr_ack;
    logic          ld_en;
    logic          ld_valid;
    logic [DW-1:0] ld_data;
    logic          ld_done;
    logic          busy;

    cpu_mem_responder #(
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .LATENCY (LAT)
    ) u_dut (
        .clk      (clk),
        .reset    (reset),
        .rd_req   (rd_req),
        .rd_addr  (rd_addr),
        .rd_ready (rd_ready),
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
        .rd_err   (rd_err),
        .wr_req   (wr_req),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_ack   (wr_ack),
        .ld_en    (ld_en),
        .ld_valid (ld_valid),
        .ld_data  (ld_data),
        .ld_done  (ld_done),
        .busy     (busy)
    );

    // Clock and watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    int n_checks = 0;
    int n_errors = 0;
    logic [DW-1:0] exp_q[$];

    typedef struct {
        logic          do_wr;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        logic [AW-1:0] ra;
        logic [DW-1:0] exp;
    } vec_t;

    vec_t vecs[7];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_write(input logic [AW-1:0] wa, input logic [DW-1:0] wd);
        wr_req  = 1'b1;
        wr_addr = wa;
        wr_data = wd;
        tick();
        wr_req = 1'b0;
        check("wr_ack", {31'd0, wr_ack}, 32'd1);
    endtask

    task automatic do_read(input logic [AW-1:0] ra, input logic [DW-1:0] exp, input logic exp_err);
        int n;
        logic [DW-1:0] e;
        exp_q.push_back(exp);
        check("rd_ready_idle", {31'd0, rd_ready}, 32'd1);
        rd_req  = 1'b1;
        rd_addr = ra;
        tick();
        rd_req = 1'b0;
        n = 1;
        while (!rd_valid && n < 12) begin
            check("rd_ready_busy", {31'd0, rd_ready}, 32'd0);
            tick();
            n++;
        end
        e = exp_q.pop_front();
        if (!rd_valid) begin
            check("rd_valid_timeout", {31'd0, rd_valid}, 32'd1);
        end else begin
            check("rd_latency", n, LAT + 1);
            check("rd_ready_in_resp", {31'd0, rd_ready}, 32'd0);
            check("rd_data", {24'd0, rd_data}, {24'd0, e});
            check("rd_err", {31'd0, rd_err}, {31'd0, exp_err});
            tick();
            check("rd_valid_pulse", {31'd0, rd_valid}, 32'd0);
            check("rd_err_pulse", {31'd0, rd_err}, 32'd0);
        end
    endtask

    initial begin
        int seen;

        vecs[0] = '{1'b0, 4'h0, 8'h00, 4'h0, 8'h13};
        vecs[1] = '{1'b0, 4'h0, 8'h00, 4'h1, 8'h21};
        vecs[2] = '{1'b0, 4'h0, 8'h00, 4'h2, 8'h05};
        vecs[3] = '{1'b1, 4'h5, 8'hA5, 4'h5, 8'hA5};
        vecs[4] = '{1'b1, 4'h0, 8'h3C, 4'h0, 8'h3C};
        vecs[5] = '{1'b1, 4'h7, 8'h00, 4'h7, 8'h00};
        vecs[6] = '{1'b0, 4'h0, 8'h00, 4'h1, 8'h21};

        reset    = 1'b1;
        rd_req   = 1'b0;
        rd_addr  = '0;
        wr_req   = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        ld_en    = 1'b0;
        ld_valid = 1'b0;
        ld_data  = '0;
        tick();
        tick();

        // Reset state
        check("reset_rd_ready", {31'd0, rd_ready}, 32'd0);
        check("reset_rd_valid", {31'd0, rd_valid}, 32'd0);
        check("reset_rd_data", {24'd0, rd_data}, 32'd0);
        check("reset_rd_err", {31'd0, rd_err}, 32'd0);
        check("reset_wr_ack", {31'd0, wr_ack}, 32'd0);
        check("reset_ld_done", {31'd0, ld_done}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        reset = 1'b0;
        #1;
        check("post_reset_rd_ready", {31'd0, rd_ready}, 32'd1);

        // Program load of three bytes
        ld_en = 1'b1;
        tick();
        check("load_busy", {31'd0, busy}, 32'd1);
        check("load_rd_ready", {31'd0, rd_ready}, 32'd0);
        ld_valid = 1'b1;
        ld_data  = {OP_LOAD, 4'h3};
        tick();
        ld_data  = {OP_ADD, 4'h1};
        tick();
        ld_data  = {OP_NOP, 4'h5};
        tick();
        ld_valid = 1'b0;
        ld_en    = 1'b0;
        tick();
        check("load_ld_done", {31'd0, ld_done}, 32'd1);
        check("load_exit_busy", {31'd0, busy}, 32'd0);
        tick();
        check("load_ld_done_pulse", {31'd0, ld_done}, 32'd0);

        // Table-driven write/read vectors
        for (int i = 0; i < 7; i++) begin
            if (vecs[i].do_wr) begin
                do_write(vecs[i].wa, vecs[i].wd);
            end
            do_read(vecs[i].ra, vecs[i].exp, 1'b0);
        end

        // Store accepted while a read sits in WAIT
        exp_q.push_back(8'h21);
        rd_req  = 1'b1;
        rd_addr = 4'h1;
        tick();
        rd_req = 1'b0;
        check("wait_busy", {31'd0, busy}, 32'd1);
        check("wait_rd_ready", {31'd0, rd_ready}, 32'd0);
        wr_req  = 1'b1;
        wr_addr = 4'h4;
        wr_data = 8'h6A;
        tick();
        wr_req = 1'b0;
        check("wait_wr_ack", {31'd0, wr_ack}, 32'd1);
        check("wait_no_valid1", {31'd0, rd_valid}, 32'd0);
        tick();
        check("wait_wr_ack_pulse", {31'd0, wr_ack}, 32'd0);
        check("wait_no_valid2", {31'd0, rd_valid}, 32'd0);
        tick();
        check("wait_rd_valid", {31'd0, rd_valid}, 32'd1);
        check("wait_rd_data", {24'd0, rd_data}, {24'd0, exp_q.pop_front()});
        tick();
        do_read(4'h4, 8'h6A, 1'b0);

        // Write to the read address on the cycle the read data is captured
        exp_q.push_back(8'hFF);
        rd_req  = 1'b1;
        rd_addr = 4'h2;
        tick();
        rd_req = 1'b0;
        tick();
        tick();
        wr_req  = 1'b1;
        wr_addr = 4'h2;
        wr_data = 8'hFF;
        tick();
        wr_req = 1'b0;
        check("fwd_rd_valid", {31'd0, rd_valid}, 32'd1);
        check("fwd_rd_data", {24'd0, rd_data}, {24'd0, exp_q.pop_front()});
        check("fwd_wr_ack", {31'd0, wr_ack}, 32'd1);
        tick();
        check("fwd_rd_data_hold", {24'd0, rd_data}, 32'hFF);
        do_read(4'h2, 8'hFF, 1'b0);

        // Reset asserted while a read is in WAIT
        rd_req  = 1'b1;
        rd_addr = 4'h0;
        tick();
        rd_req = 1'b0;
        tick();
        reset = 1'b1;
        #1;
        check("rst_wait_rd_ready", {31'd0, rd_ready}, 32'd0);
        check("rst_wait_rd_valid", {31'd0, rd_valid}, 32'd0);
        check("rst_wait_rd_data", {24'd0, rd_data}, 32'd0);
        check("rst_wait_busy", {31'd0, busy}, 32'd0);
        check("rst_wait_wr_ack", {31'd0, wr_ack}, 32'd0);
        tick();
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (rd_valid) seen++;
        end
        check("rst_wait_no_valid", seen, 0);
        do_read(4'h0, 8'h3C, 1'b0);

        // ld_en wins over rd_req; stores ignored in LOAD; pointer restarts at 0
        ld_en   = 1'b1;
        rd_req  = 1'b1;
        rd_addr = 4'h1;
        tick();
        rd_req = 1'b0;
        check("ld_prio_busy", {31'd0, busy}, 32'd1);
        wr_req  = 1'b1;
        wr_addr = 4'h6;
        wr_data = 8'h77;
        tick();
        wr_req = 1'b0;
        check("ld_wr_ignored", {31'd0, wr_ack}, 32'd0);
        ld_valid = 1'b1;
        ld_data  = 8'h42;
        tick();
        ld_valid = 1'b0;
        ld_en    = 1'b0;
        check("ld_no_valid", {31'd0, rd_valid}, 32'd0);
        tick();
        check("ld2_ld_done", {31'd0, ld_done}, 32'd1);
        check("ld2_rd_valid", {31'd0, rd_valid}, 32'd0);
        tick();
        check("ld2_ld_done_pulse", {31'd0, ld_done}, 32'd0);
        do_read(4'h0, 8'h42, 1'b0);
        do_read(4'h1, 8'h21, 1'b0);

`ifdef CPU_MEM_PARITY_EN
        // Corrupt the stored parity bit of addr 0
        u_dut.u_array.mem[0][DW] = ~u_dut.u_array.mem[0][DW];
        do_read(4'h0, 8'h42, 1'b1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
